// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (P) and a queued mul/div result (M).
// P is granted in the same cycle; an M result is written no earlier than the cycle after it is pushed.
// m_ready drops while the FIFO is full; p_ready drops for one cycle when the head M entry has starved.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            p_valid,
  output logic            p_ready,
  input  logic [4:0]      p_waddr,
  input  logic [XLEN-1:0] p_wdata,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [4:0]      m_waddr,
  input  logic [XLEN-1:0] m_wdata,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      hz_raddr1,
  input  logic [4:0]      hz_raddr2,
  output logic            hz_stall,
  output logic            m_pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        waddr_q [DEPTH];
  logic [4:0]        waddr_d [DEPTH];
  logic [XLEN-1:0]   wdata_q [DEPTH];
  logic [XLEN-1:0]   wdata_d [DEPTH];
  logic [DEPTH-1:0]  live_q, live_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [GW-1:0]     age_q, age_d;

  logic              empty, head_live, grant_p, pop, push, kill, push_live, wen_raw;

  always_comb begin
    empty     = (count_q == '0);
    head_live = live_q[rd_ptr_q];
    m_pending = !empty;
    m_ready   = (count_q < CW'(DEPTH));
    p_ready   = (state_q == NORMAL);
    grant_p   = p_valid && p_ready;
    pop       = !empty && !grant_p;
    push      = m_valid && m_ready;
    kill      = grant_p && (p_waddr != 5'd0);
    // P is younger than any M result, including one arriving this same cycle.
    push_live = !(kill && (m_waddr == p_waddr));

    wen_raw  = 1'b0;
    rf_waddr = p_waddr;
    rf_wdata = p_wdata;
    if (grant_p) begin
      wen_raw = (p_waddr != 5'd0);
    end else if (pop) begin
      rf_waddr = waddr_q[rd_ptr_q];
      rf_wdata = wdata_q[rd_ptr_q];
      wen_raw  = head_live && (waddr_q[rd_ptr_q] != 5'd0);
    end
    rf_wen = wen_raw && reset_n;

    hz_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (((waddr_q[i] == hz_raddr1) && (hz_raddr1 != 5'd0)) ||
                        ((waddr_q[i] == hz_raddr2) && (hz_raddr2 != 5'd0))))
        hz_stall = 1'b1;
    end
  end

  always_comb begin
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    live_d   = live_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    age_d    = age_q;
    state_d  = NORMAL;

    if (kill) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr_q[i] == p_waddr) live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + 1'b1;
    end
    if (push) begin
      waddr_d[wr_ptr_q] = m_waddr;
      wdata_d[wr_ptr_q] = m_wdata;
      live_d[wr_ptr_q]  = push_live;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end

    // A live result pushed into an empty FIFO starts waiting in its push cycle.
    if (pop) begin
      age_d = '0;
    end else if (grant_p && (head_live || (empty && push && push_live)) &&
                 (age_q != GW'(STARVE_LIMIT))) begin
      age_d = age_q + 1'b1;
    end

    if ((state_q == NORMAL) && head_live && p_valid &&
        (age_q >= GW'(STARVE_LIMIT - 1)))
      state_d = FORCE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= NORMAL;
      waddr_q  <= '{default: '0};
      wdata_q  <= '{default: '0};
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
    end
  end
endmodule
